encap_packet: RTL and testbench

//  Transmit-side counterpart of the output-port DFX decapsulator. Takes one
//  1034-bit DFX word ({addr[9:0], data[1023:0]}) and serialises it into 19
//  64-bit Aurora user frames. Payload sits in bits [63:9]; bits [8:0] are a

---
 rtl/encap_pkg.sv | 26 ++
 rtl/encap_frame_slice.sv | 41 ++++
 rtl/encap_packet.sv | 109 ++++++++++
 tb/tb_encap_packet.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/encap_pkg.sv
// Shared constants and types for the DFX-to-Aurora packet encapsulator.
// Geometry: 1034-bit word -> 18 frames of 55 payload bits + one of 44 bits.
package encap_pkg;

   localparam int DATA_WIDTH        = 1024;
   localparam int ADDR_WIDTH        = 10;
   localparam int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH;
   localparam int AURORA_DATA_WIDTH = 64;

   localparam int FRAME_PAYLOAD = 55;
   localparam int NUM_FRAMES    = 19;
   localparam int LAST_PAYLOAD  = 44;
   localparam int HDR_WIDTH     = 9;
   localparam int HDR_SOF_BIT   = 8;
   localparam int HDR_EOF_BIT   = 7;
   localparam int HDR_IDX_LSB   = 2;

   localparam int CNT_W = 5;
   localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(NUM_FRAMES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

endpackage

// File: rtl/encap_frame_slice.sv
// Combinational frame builder: selects the payload slice for frame_cnt and
// prepends the SOF/EOF/index header (plus parity when ENCAP_PARITY_EN is defined).
module encap_frame_slice
   import encap_pkg::*;
(
   input  logic [DATA_DFX_WIDTH-1:0]    word,
   input  logic [CNT_W-1:0]             frame_cnt,
   output logic [AURORA_DATA_WIDTH-1:0] frame
);

   logic [FRAME_PAYLOAD-1:0] payload_arr [NUM_FRAMES];
   logic [FRAME_PAYLOAD-1:0] payload;
   logic [HDR_WIDTH-1:0]     hdr;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FRAMES - 1; gi++) begin : g_full
         assign payload_arr[gi] = word[gi*FRAME_PAYLOAD +: FRAME_PAYLOAD];
      end
   endgenerate

   // The last frame carries only the top 44 bits; its upper payload bits are zero.
   assign payload_arr[NUM_FRAMES-1] =
      {{(FRAME_PAYLOAD-LAST_PAYLOAD){1'b0}}, word[DATA_DFX_WIDTH-1 -: LAST_PAYLOAD]};

   always_comb begin
      payload = '0;
      if (frame_cnt <= LAST_FRAME) begin
         payload = payload_arr[frame_cnt];
      end
      hdr = '0;
      hdr[HDR_SOF_BIT] = (frame_cnt == '0);
      hdr[HDR_EOF_BIT] = (frame_cnt == LAST_FRAME);
      hdr[HDR_IDX_LSB +: CNT_W] = frame_cnt;
      frame = {payload, hdr};
`ifdef ENCAP_PARITY_EN
      frame[0] = ^frame[AURORA_DATA_WIDTH-1:1];
`endif
   end

endmodule

// File: rtl/encap_packet.sv
// Serialises one 1034-bit DFX word into 19 registered 64-bit Aurora frames.
// Optional header parity bit is enabled by defining ENCAP_PARITY_EN.
module encap_packet
   import encap_pkg::*;
#(
   parameter int DATA_WIDTH_P        = DATA_WIDTH,
   parameter int ADDR_WIDTH_P        = ADDR_WIDTH,
   parameter int DATA_DFX_WIDTH_P    = DATA_WIDTH_P + ADDR_WIDTH_P,
   parameter int AURORA_DATA_WIDTH_P = AURORA_DATA_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [DATA_DFX_WIDTH_P-1:0]    data_dfx_in,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [AURORA_DATA_WIDTH_P-1:0] tx_tdata,
   output logic                           tx_tvalid,
   output logic                           tx_tlast,
   input  logic                           tx_tready,
   output logic                           busy,
   output logic                           done_encap_pkt
);

   state_e                         state_q, state_d;
   logic [CNT_W-1:0]               frame_cnt_q, frame_cnt_d;
   logic [DATA_DFX_WIDTH_P-1:0]    word_q, word_d;
   logic [AURORA_DATA_WIDTH_P-1:0] tdata_q, tdata_d;
   logic                           tvalid_q, tvalid_d;
   logic                           tlast_q, tlast_d;
   logic                           done_q, done_d;
   logic [AURORA_DATA_WIDTH_P-1:0] next_frame;
   logic                           handshake;
   logic                           accept;

   // Frame is built from the *next* word/count so the output stage stays registered.
   encap_frame_slice u_slice (
      .word      (word_d),
      .frame_cnt (frame_cnt_d),
      .frame     (next_frame)
   );

   assign handshake = tvalid_q && tx_tready;
   assign in_ready  = (state_q == IDLE) ||
                      ((state_q == SEND) && (frame_cnt_q == LAST_FRAME) && tx_tready);
   assign accept    = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      word_d      = word_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d     = SEND;
               frame_cnt_d = '0;
               word_d      = data_dfx_in;
            end
         end
         SEND: begin
            if (handshake) begin
               if (frame_cnt_q == LAST_FRAME) begin
                  done_d      = 1'b1;
                  frame_cnt_d = '0;
                  if (accept) begin
                     word_d = data_dfx_in;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  frame_cnt_d = frame_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      tvalid_d = (state_d == SEND);
      tlast_d  = tvalid_d && (frame_cnt_d == LAST_FRAME);
      tdata_d  = tvalid_d ? next_frame : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         frame_cnt_q <= '0;
         word_q      <= '0;
         tdata_q     <= '0;
         tvalid_q    <= 1'b0;
         tlast_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         word_q      <= word_d;
         tdata_q     <= tdata_d;
         tvalid_q    <= tvalid_d;
         tlast_q     <= tlast_d;
         done_q      <= done_d;
      end
   end

   assign tx_tdata       = tdata_q;
   assign tx_tvalid      = tvalid_q;
   assign tx_tlast       = tlast_q;
   assign busy           = (state_q == SEND);
   assign done_encap_pkt = done_q;

endmodule

// File: tb/tb_encap_packet.sv
// Self-checking bench for encap_packet: queue-based frame model, directed
// scenarios (pattern, backpressure, back-to-back, all-ones, reset) plus random traffic.
module tb_encap_packet;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1033:0] data_dfx_in;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   tx_tdata;
   logic          tx_tvalid;
   logic          tx_tlast;
   logic          tx_tready;
   logic          busy;
   logic          done_encap_pkt;

   int checks   = 0;
   int failures = 0;

   logic [63:0] exp_q [$];
   logic [63:0] got_q [$];
   logic        done_exp = 1'b0;
   int          done_seen = 0;

   always #5 clk = ~clk;

   encap_packet dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_dfx_in    (data_dfx_in),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .tx_tdata       (tx_tdata),
      .tx_tvalid      (tx_tvalid),
      .tx_tlast       (tx_tlast),
      .tx_tready      (tx_tready),
      .busy           (busy),
      .done_encap_pkt (done_encap_pkt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [1033:0] obs, input logic [1033:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed_lo=%0h expected_lo=%0h observed_hi=%0h expected_hi=%0h",
                tag, obs[63:0], exp[63:0], obs[1033:970], exp[1033:970]);
      end
   endtask

   // Frame k carries word bits starting at k*55; header = SOF/EOF flags and the index.
   function automatic logic [63:0] ref_frame(input logic [1033:0] w, input int k);
      logic [1033:0] s;
      logic [8:0]    hdr;
      logic [63:0]   f;
      s   = w >> (k * 55);
      hdr = 9'(((k == 0) ? 256 : 0) + ((k == 18) ? 128 : 0) + k * 4);
      f   = {s[54:0], hdr};
`ifdef ENCAP_PARITY_EN
      f[0] = ^f[63:1];
`endif
      return f;
   endfunction

   function automatic logic [1033:0] rand_word();
      logic [1055:0] t;
      for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
      return t[1033:0];
   endfunction

   task automatic push_word(input logic [1033:0] w);
      for (int k = 0; k < 19; k++) exp_q.push_back(ref_frame(w, k));
   endtask

   // One clock cycle: drive inputs after the falling edge, check, then advance the model.
   task automatic step(input logic rdy, input logic vld, input logic [1033:0] w, output logic acc);
      logic        pending;
      logic        exp_rdy;
      logic        was_last;
      logic [63:0] exp_td;
      @(negedge clk);
      tx_tready   = rdy;
      in_valid    = vld;
      data_dfx_in = w;
      #1;
      pending = (exp_q.size() != 0);
      exp_td  = '0;
      if (pending) exp_td = exp_q[0];
      exp_rdy = !pending || ((exp_q.size() == 1) && rdy);
      chk("tvalid", 64'(tx_tvalid), 64'(pending));
      chk("tdata", tx_tdata, exp_td);
      chk("tlast", 64'(tx_tlast), 64'(exp_td[7]));
      chk("busy", 64'(busy), 64'(pending));
      chk("done", 64'(done_encap_pkt), 64'(done_exp));
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (done_encap_pkt) done_seen++;
      was_last = 1'b0;
      if (pending && rdy) begin
         got_q.push_back(tx_tdata);
         was_last = exp_td[7];
         void'(exp_q.pop_front());
      end
      acc = vld && exp_rdy;
      if (acc) push_word(w);
      done_exp = was_last;
   endtask

   // mode 0: tready=1; mode 1: 1010 pattern with a 5-cycle stall at frame 7; mode 2: random.
   task automatic send_packet(input logic [1033:0] w, input int mode);
      logic acc;
      logic r;
      int   cyc;
      int   drain;
      int   stalls;
      acc = 1'b0; cyc = 0; drain = 0; stalls = 0;
      got_q.delete();
      while (!acc && cyc < 200) begin
         step(1'b1, 1'b1, w, acc);
         cyc++;
      end
      while (exp_q.size() != 0 && cyc < 400) begin
         if (mode == 0) r = 1'b1;
         else if (mode == 1) begin
            if (got_q.size() == 7 && stalls < 5) begin r = 1'b0; stalls++; end
            else r = cyc[0];
         end else r = 1'($urandom_range(0, 1));
         step(r, 1'b0, '0, acc);
         cyc++;
         drain++;
      end
      step(1'b1, 1'b0, '0, acc);
      chk("pkt_drained", 64'(exp_q.size()), 64'd0);
      chk("frames_accepted", 64'(got_q.size()), 64'd19);
      if (mode == 0) chk("cycles_per_packet", 64'(drain), 64'd19);
      $display("packet mode=%0d frames=%0d cycles=%0d stalls=%0d", mode, got_q.size(), drain, stalls);
   endtask

   task automatic decap_check(input logic [1033:0] w);
      logic [1033:0] rec;
      rec = '0;
      if (got_q.size() == 19) begin
         for (int k = 0; k < 18; k++) rec[k*55 +: 55] = got_q[k][63:9];
         rec[1033:990] = got_q[18][52:9];
         chk("f18_pad_zero", 64'(got_q[18][63:53]), 64'd0);
      end
      chk_word("decap_word", rec, w);
   endtask

   initial begin
      logic [1033:0] w;
      logic [1033:0] w2;
      logic [1039:0] tmp;
      logic [1033:0] pend;
      logic          acc;
      logic          v;
      logic          r;
      int            sent;
      int            cyc;

      rst_n = 1'b0; in_valid = 1'b0; tx_tready = 1'b0; data_dfx_in = '0;
      #1;
      chk("rst_tvalid", 64'(tx_tvalid), 64'd0);
      chk("rst_tdata", tx_tdata, 64'd0);
      chk("rst_tlast", 64'(tx_tlast), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done_encap_pkt), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Incrementing byte pattern
      for (int i = 0; i < 130; i++) tmp[i*8 +: 8] = 8'(i);
      w = tmp[1033:0];
      send_packet(w, 0);
      decap_check(w);
      if (got_q.size() == 19) begin
         chk("f0_hdr_upper", 64'(got_q[0][8:1]), 64'h80);
         chk("f18_hdr_upper", 64'(got_q[18][8:1]), 64'h64);
`ifndef ENCAP_PARITY_EN
         chk("f0_hdr", 64'(got_q[0][8:0]), 64'h100);
         chk("f18_hdr", 64'(got_q[18][8:0]), 64'h0C8);
`endif
      end

      // Backpressure
      w = rand_word();
      send_packet(w, 1);
      decap_check(w);

      // Back-to-back: in_valid held across both words
      w  = rand_word();
      w2 = rand_word();
      done_seen = 0;
      sent = 0;
      cyc  = 0;
      got_q.delete();
      while (sent < 2 && cyc < 200) begin
         step(1'b1, 1'b1, (sent == 0) ? w : w2, acc);
         if (acc) sent++;
         cyc++;
      end
      while (exp_q.size() != 0 && cyc < 400) begin
         step(1'b1, 1'b0, '0, acc);
         cyc++;
      end
      step(1'b1, 1'b0, '0, acc);
      chk("b2b_frames", 64'(got_q.size()), 64'd38);
      chk("b2b_done_pulses", 64'(done_seen), 64'd2);
      $display("back_to_back frames=%0d done_pulses=%0d", got_q.size(), done_seen);

      // All-ones boundary
      w = '1;
      send_packet(w, 0);
      decap_check(w);
      if (got_q.size() == 19) begin
         chk("ones_f18_payload", 64'(got_q[18][52:9]), 64'hFFF_FFFF_FFFF);
         chk("ones_f0_bit0", 64'(got_q[0][0]), 64'd0);
      end

      // Reset mid-packet
      w = rand_word();
      step(1'b1, 1'b1, w, acc);
      repeat (8) step(1'b1, 1'b0, '0, acc);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_tvalid", 64'(tx_tvalid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_tdata", tx_tdata, 64'd0);
      exp_q.delete();
      done_exp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      $display("reset mid-packet applied");
      w = rand_word();
      send_packet(w, 0);
      decap_check(w);
      if (got_q.size() != 0) chk("post_rst_sof", 64'(got_q[0][8]), 64'd1);

      // Random traffic with random tready and in_valid gaps
      done_seen = 0;
      sent = 0;
      cyc  = 0;
      v    = 1'b0;
      pend = rand_word();
      while ((sent < 6 || exp_q.size() != 0) && cyc < 3000) begin
         if (!v && sent < 6) v = ($urandom_range(0, 3) != 0);
         r = 1'($urandom_range(0, 1));
         step(r, v, pend, acc);
         if (acc) begin
            sent++;
            v = 1'b0;
            pend = rand_word();
         end
         cyc++;
      end
      step(1'b1, 1'b0, '0, acc);
      chk("rand_sent", 64'(sent), 64'd6);
      chk("rand_drained", 64'(exp_q.size()), 64'd0);
      chk("rand_done_pulses", 64'(done_seen), 64'd6);
      $display("random packets=%0d cycles=%0d done_pulses=%0d", sent, cyc, done_seen);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
